// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: boot sequencer that freezes the core, streams CCE ucode from a ROM,
// writes the cache/CCE modes and boot NPC over the uncached mem_cmd port, then unfreezes.
package bp_cfg_loader_pkg;
  typedef enum logic [0:0] {e_bp_inv_cfg = 1'b0} bp_params_e;
  typedef struct packed {
    int paddr_width;
    int vaddr_width;
    int cce_pc_width;
    int cce_instr_width;
    int cce_block_width;
  } bp_proc_param_s;
  function automatic bp_proc_param_s bp_get_proc_params(bp_params_e p);
    bp_proc_param_s r;
    r = '0;
    case (p)
      e_bp_inv_cfg: r = '{paddr_width: 40, vaddr_width: 39, cce_pc_width: 8, cce_instr_width: 48, cce_block_width: 64};
      default: r = '0;
    endcase
    return r;
  endfunction
  typedef enum logic [1:0] {e_cce_mode_uncached, e_cce_mode_normal} bp_cce_mode_e;
  typedef enum logic [1:0] {e_lce_mode_uncached, e_lce_mode_normal, e_lce_mode_nonspec} bp_lce_mode_e;
  typedef enum logic [3:0] {e_cce_mem_rd, e_cce_mem_wr, e_cce_mem_uc_rd, e_cce_mem_uc_wr} bp_cce_mem_cmd_type_e;
  typedef enum logic [2:0] {e_mem_size_1, e_mem_size_2, e_mem_size_4, e_mem_size_8} bp_mem_size_e;
  localparam logic [15:0] bp_cfg_reg_freeze_gp         = 16'h0008;
  localparam logic [15:0] bp_cfg_reg_npc_gp            = 16'h0010;
  localparam logic [15:0] bp_cfg_reg_icache_mode_gp    = 16'h0018;
  localparam logic [15:0] bp_cfg_reg_dcache_mode_gp    = 16'h0020;
  localparam logic [15:0] bp_cfg_reg_cce_mode_gp       = 16'h0028;
  localparam logic [15:0] bp_cfg_mem_base_cce_ucode_gp = 16'h8000;
endpackage

module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
 #(parameter bp_params_e bp_params_p = e_bp_inv_cfg
  , parameter int ucode_depth_p = 256
  , parameter int credits_p = 2
  , localparam bp_proc_param_s proc_lp = bp_get_proc_params(bp_params_p)
  , localparam int paddr_width_p = proc_lp.paddr_width
  , localparam int vaddr_width_p = proc_lp.vaddr_width
  , localparam int cce_pc_width_p = proc_lp.cce_pc_width
  , localparam int cce_instr_width_p = proc_lp.cce_instr_width
  , localparam int cce_block_width_p = proc_lp.cce_block_width
  , localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + 8 + cce_block_width_p
  )
  (input  logic clk_i
  , input  logic reset_n_i
  , input  logic start_i
  , input  logic skip_ucode_i
  , input  logic [vaddr_width_p-1:0] boot_npc_i
  , input  logic [$bits(bp_cce_mode_e)-1:0] cce_mode_i
  , input  logic [$bits(bp_lce_mode_e)-1:0] lce_mode_i
  , output logic [cce_pc_width_p-1:0] rom_addr_o
  , output logic rom_v_o
  , input  logic [cce_instr_width_p-1:0] rom_data_i
  , output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o
  , output logic mem_cmd_v_o
  , input  logic mem_cmd_ready_i
  , input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i
  , input  logic mem_resp_v_i
  , output logic mem_resp_yumi_o
  , output logic busy_o
  , output logic done_o
  , output logic error_o
  );

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    logic [7:0] payload;
    bp_mem_size_e size;
    logic [paddr_width_p-1:0] addr;
    bp_cce_mem_cmd_type_e msg_type;
  } msg_s;

  typedef enum logic [3:0] {
    e_idle, e_freeze, e_uc_rd, e_uc_wr, e_cce_mode, e_i_mode, e_d_mode, e_npc, e_unfreeze, e_drain, e_done
  } state_e;

  localparam int cw_lp = $clog2(credits_p + 1);

  state_e state_r, state_n;
  logic skip_r, uc_first_r, error_r;
  logic [vaddr_width_p-1:0] npc_r;
  logic [$bits(bp_cce_mode_e)-1:0] cce_mode_r;
  logic [$bits(bp_lce_mode_e)-1:0] lce_mode_r;
  logic [cce_pc_width_p-1:0] idx_r;
  logic [cce_instr_width_p-1:0] instr_r;
  logic [cw_lp-1:0] cnt_r;
  logic [15:0] cfg_addr;
  logic [cce_block_width_p-1:0] cfg_data;
  logic idle_or_done, launch, cmd_state, cmd_hs, resp_dec, last_uc, unused_resp;
  msg_s cmd, resp;

  assign resp = msg_s'(mem_resp_i);
  assign unused_resp = ^{resp.data, resp.payload, resp.size, resp.addr};
  assign idle_or_done = state_r == e_idle || state_r == e_done;
  assign launch = start_i & idle_or_done;
  assign cmd_state = !(state_r inside {e_idle, e_uc_rd, e_drain, e_done});
  assign mem_cmd_v_o = cmd_state & (cnt_r != cw_lp'(credits_p));
  assign cmd_hs = mem_cmd_v_o & mem_cmd_ready_i;
  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped silently
  assign resp_dec = mem_resp_v_i & (cnt_r != '0);
  assign last_uc = idx_r == cce_pc_width_p'(ucode_depth_p - 1);
  assign mem_resp_yumi_o = mem_resp_v_i;
  assign rom_v_o = state_r == e_uc_rd;
  assign rom_addr_o = idx_r;
  assign busy_o = !idle_or_done;
  assign done_o = state_r == e_done;
  assign error_o = error_r;
  assign mem_cmd_o = cmd;

  always_comb begin
    cfg_addr = '0;
    cfg_data = '0;
    case (state_r)
      e_freeze:   begin cfg_addr = bp_cfg_reg_freeze_gp; cfg_data = cce_block_width_p'(1); end
      // ROM output is only valid on the first UC_WR cycle; later cycles use the captured copy
      e_uc_wr:    begin cfg_addr = bp_cfg_mem_base_cce_ucode_gp + 16'(idx_r); cfg_data = cce_block_width_p'(uc_first_r ? rom_data_i : instr_r); end
      e_cce_mode: begin cfg_addr = bp_cfg_reg_cce_mode_gp; cfg_data = cce_block_width_p'(cce_mode_r); end
      e_i_mode:   begin cfg_addr = bp_cfg_reg_icache_mode_gp; cfg_data = cce_block_width_p'(lce_mode_r); end
      e_d_mode:   begin cfg_addr = bp_cfg_reg_dcache_mode_gp; cfg_data = cce_block_width_p'(lce_mode_r); end
      e_npc:      begin cfg_addr = bp_cfg_reg_npc_gp; cfg_data = cce_block_width_p'(npc_r); end
      e_unfreeze: cfg_addr = bp_cfg_reg_freeze_gp;
      default:    cfg_addr = '0;
    endcase
    cmd = '{data: cfg_data, payload: '0, size: e_mem_size_8, addr: paddr_width_p'(cfg_addr), msg_type: e_cce_mem_uc_wr};
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle, e_done: state_n = start_i ? e_freeze : state_r;
      e_freeze:       state_n = cmd_hs ? (skip_r ? e_cce_mode : e_uc_rd) : state_r;
      e_uc_rd:        state_n = e_uc_wr;
      e_uc_wr:        state_n = cmd_hs ? (last_uc ? e_cce_mode : e_uc_rd) : state_r;
      e_cce_mode:     state_n = cmd_hs ? e_i_mode : state_r;
      e_i_mode:       state_n = cmd_hs ? e_d_mode : state_r;
      e_d_mode:       state_n = cmd_hs ? e_npc : state_r;
      e_npc:          state_n = cmd_hs ? e_unfreeze : state_r;
      e_unfreeze:     state_n = cmd_hs ? e_drain : state_r;
      e_drain:        state_n = cnt_r == '0 ? e_done : state_r;
      default:        state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      cnt_r <= '0;
      idx_r <= '0;
      error_r <= 1'b0;
      uc_first_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r <= cnt_r + cw_lp'(cmd_hs) - cw_lp'(resp_dec);
      uc_first_r <= rom_v_o;
      if (launch) begin
        idx_r <= '0;
        error_r <= 1'b0;
      end else begin
        if (state_r == e_uc_wr && cmd_hs && !last_uc) idx_r <= idx_r + 1'b1;
        if (resp_dec && resp.msg_type != e_cce_mem_uc_wr) error_r <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (uc_first_r) instr_r <= rom_data_i;
    if (launch) begin
      skip_r <= skip_ucode_i;
      npc_r <= boot_npc_i;
      cce_mode_r <= cce_mode_i;
      lce_mode_r <= lce_mode_i;
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// tb_bp_cfg_loader: scoreboard bench with a ROM model and a credit-aware config endpoint model.
module tb_bp_cfg_loader;
  import bp_cfg_loader_pkg::*;

  localparam bp_proc_param_s pp = bp_get_proc_params(e_bp_inv_cfg);
  localparam int pa_w = pp.paddr_width;
  localparam int va_w = pp.vaddr_width;
  localparam int pc_w = pp.cce_pc_width;
  localparam int in_w = pp.cce_instr_width;
  localparam int bl_w = pp.cce_block_width;
  localparam int msg_w = 4 + pa_w + 3 + 8 + bl_w;
  localparam int depth = 4;
  localparam int credits = 2;

  typedef struct packed {
    logic [bl_w-1:0] data;
    logic [7:0] payload;
    logic [2:0] size;
    logic [pa_w-1:0] addr;
    logic [3:0] msg_type;
  } msg_s;
  typedef struct { int due; bit bad; } resp_t;
  typedef struct { logic [pa_w-1:0] addr; logic [bl_w-1:0] data; } exp_t;

  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic start_i = 1'b0;
  logic skip_ucode_i = 1'b0;
  logic [va_w-1:0] boot_npc_i = '0;
  logic [1:0] cce_mode_i = '0;
  logic [1:0] lce_mode_i = '0;
  logic [pc_w-1:0] rom_addr_o;
  logic rom_v_o;
  logic [in_w-1:0] rom_q = '0;
  logic [msg_w-1:0] mem_cmd_o;
  logic mem_cmd_v_o;
  logic mem_cmd_ready_i = 1'b0;
  logic [msg_w-1:0] mem_resp_i = '0;
  logic mem_resp_v_i = 1'b0;
  logic mem_resp_yumi_o, busy_o, done_o, error_o;

  bp_cfg_loader #(.bp_params_p(e_bp_inv_cfg), .ucode_depth_p(depth), .credits_p(credits)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i), .skip_ucode_i(skip_ucode_i),
    .boot_npc_i(boot_npc_i), .cce_mode_i(cce_mode_i), .lce_mode_i(lce_mode_i),
    .rom_addr_o(rom_addr_o), .rom_v_o(rom_v_o), .rom_data_i(rom_q),
    .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_yumi_o(mem_resp_yumi_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o));

  always #5 clk = ~clk;

  function automatic logic [in_w-1:0] rom_word(logic [pc_w-1:0] a);
    return {16'hC0DE, 8'(a ^ 8'h5A), 8'(a), 16'(16'(a) * 16'h0101 + 16'h1234)};
  endfunction

  // Synchronous ROM whose output is junk except the cycle after a read
  always @(posedge clk) rom_q <= rom_v_o ? rom_word(rom_addr_o) : in_w'({$urandom(), $urandom()});

  int n_chk = 0, n_fail = 0;
  task automatic chk(string tag, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  exp_t sb[$];
  resp_t due_q[$];
  int cyc = 0, outst = 0, hs_seq = 0, rom_pulses = 0, bad_idx = -1, delay = 1;
  bit rdy_rand = 0, prev_stall = 0;
  logic [15:0] stall_addr = 16'hFFFF;
  msg_s c, prev_cmd, rs;
  exp_t e;
  resp_t r;

  always @(negedge clk) begin
    cyc++;
    if (mem_resp_v_i) begin
      chk("yumi", mem_resp_yumi_o, 1'b1);
      if (outst > 0) outst--;
    end
    c = msg_s'(mem_cmd_o);
    mem_cmd_ready_i = (mem_cmd_v_o && c.addr == pa_w'(stall_addr)) ? 1'b0 : rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (start_i && !busy_o) begin hs_seq = 0; rom_pulses = 0; end
    if (!reset_n_i) begin
      outst = 0;
      prev_stall = 0;
    end else begin
      rom_pulses += int'(rom_v_o);
      if (prev_stall) begin
        chk("cmd_stable", mem_cmd_o, prev_cmd);
        chk("v_held", mem_cmd_v_o, 1'b1);
      end
      if (mem_cmd_v_o && mem_cmd_ready_i) begin
        chk("credits", outst < credits, 1'b1);
        chk("msg_type", c.msg_type, e_cce_mem_uc_wr);
        chk("size", c.size, e_mem_size_8);
        chk("payload", c.payload, 8'h0);
        chk("sb_under", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("addr", c.addr, e.addr);
          chk("data", c.data, e.data);
        end
        due_q.push_back('{cyc + delay, hs_seq == bad_idx});
        hs_seq++;
        outst++;
      end
      prev_stall = mem_cmd_v_o && !mem_cmd_ready_i;
      prev_cmd = mem_cmd_o;
    end
    rs = '0;
    if (due_q.size() > 0 && due_q[0].due <= cyc) begin
      r = due_q.pop_front();
      rs.msg_type = r.bad ? e_cce_mem_uc_rd : e_cce_mem_uc_wr;
      rs.size = e_mem_size_8;
      mem_resp_v_i = 1'b1;
    end else mem_resp_v_i = 1'b0;
    mem_resp_i = rs;
  end

  task automatic push_exp(bit skip, logic [va_w-1:0] npc, logic [1:0] cm, logic [1:0] lm);
    sb.push_back('{pa_w'(bp_cfg_reg_freeze_gp), bl_w'(1)});
    if (!skip) for (int i = 0; i < depth; i++) sb.push_back('{pa_w'(16'h8000 + 16'(i)), bl_w'(rom_word(pc_w'(i)))});
    sb.push_back('{pa_w'(bp_cfg_reg_cce_mode_gp), bl_w'(cm)});
    sb.push_back('{pa_w'(bp_cfg_reg_icache_mode_gp), bl_w'(lm)});
    sb.push_back('{pa_w'(bp_cfg_reg_dcache_mode_gp), bl_w'(lm)});
    sb.push_back('{pa_w'(bp_cfg_reg_npc_gp), bl_w'(npc)});
    sb.push_back('{pa_w'(bp_cfg_reg_freeze_gp), bl_w'(0)});
  endtask

  task automatic pulse_start(bit skip, logic [va_w-1:0] npc, logic [1:0] cm, logic [1:0] lm);
    @(posedge clk); #1;
    start_i = 1'b1; skip_ucode_i = skip; boot_npc_i = npc; cce_mode_i = cm; lce_mode_i = lm;
    @(posedge clk); #1;
    start_i = 1'b0; skip_ucode_i = ~skip; boot_npc_i = ~npc; cce_mode_i = ~cm; lce_mode_i = ~lm;
    @(negedge clk);
    chk("start_lat_v", mem_cmd_v_o, 1'b1);
    chk("start_busy", busy_o, 1'b1);
    chk("start_err_clr", error_o, 1'b0);
    chk("start_done_clr", done_o, 1'b0);
  endtask

  task automatic run(bit skip, logic [va_w-1:0] npc, logic [1:0] cm, logic [1:0] lm, bit exp_err, bit poke);
    int n;
    push_exp(skip, npc, cm, lm);
    pulse_start(skip, npc, cm, lm);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    n = 0;
    while (!done_o && n < 3000) begin @(negedge clk); n++; end
    chk("done", done_o, 1'b1);
    chk("busy_end", busy_o, 1'b0);
    chk("error_end", error_o, exp_err);
    chk("sb_left", sb.size(), 0);
    chk("n_cmds", hs_seq, skip ? 6 : depth + 6);
    chk("rom_pulses", rom_pulses, skip ? 0 : depth);
    sb.delete();
  endtask

  initial begin
    int n;
    bit found;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_v", mem_cmd_v_o, 1'b0);
    chk("rst_rom_v", rom_v_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_rom_addr", rom_addr_o, 0);
    @(posedge clk); #1 reset_n_i = 1'b1;

    run(0, 39'h12_3456_7890, 2'd1, 2'd1, 0, 0);
    run(1, 39'h7F_0000_1004, 2'd0, 2'd2, 0, 0);
    rdy_rand = 1; delay = 5;
    run(0, 39'h00_ABCD_0040, 2'd1, 2'd0, 0, 0);
    rdy_rand = 0; delay = 1; bad_idx = 3;
    run(0, 39'h40_0000_0000, 2'd1, 2'd1, 1, 0);
    bad_idx = -1;
    repeat (3) @(negedge clk);
    chk("err_held", error_o, 1'b1);
    chk("done_held", done_o, 1'b1);
    run(0, 39'h01_2345_6789, 2'd0, 2'd1, 0, 1);

    stall_addr = 16'h8002; delay = 8;
    push_exp(0, 39'h55_5555_5555, 2'd1, 2'd1);
    pulse_start(0, 39'h55_5555_5555, 2'd1, 2'd1);
    found = 0; n = 0;
    while (!found && n < 500) begin
      @(negedge clk); n++;
      c = msg_s'(mem_cmd_o);
      found = mem_cmd_v_o && c.addr == pa_w'(16'h8002);
    end
    chk("reach_idx2", found, 1'b1);
    @(posedge clk); #1 reset_n_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmd_v", mem_cmd_v_o, 1'b0);
    chk("mid_rst_rom_v", rom_v_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    chk("mid_rst_error", error_o, 1'b0);
    chk("mid_rst_rom_addr", rom_addr_o, 0);
    sb.delete();
    stall_addr = 16'hFFFF; delay = 1;
    @(posedge clk); #1 reset_n_i = 1'b1;
    n = 0;
    while (due_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("post_rst_error", error_o, 1'b0);
    run(0, 39'h2A_1357_9BDF, 2'd1, 2'd2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
